// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/Mem DRAM port arbiter.
// Imported by mem_port_arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } arb_owner_e;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-ported DRAM arbiter: data port over fetch, starvation
// guard for fetch, fetch kill on flush, and response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = ARB_ERR_DATA
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        if_req_ip,
    input  logic [31:0] if_addr_ip,
    input  logic        if_kill_ip,
    output logic        if_gnt_op,
    output logic        if_rvalid_op,
    output logic [31:0] if_rdata_op,
    input  logic        d_req_ip,
    input  logic        d_we_ip,
    input  logic [3:0]  d_be_ip,
    input  logic [31:0] d_addr_ip,
    input  logic [31:0] d_wdata_ip,
    output logic        d_gnt_op,
    output logic        d_rvalid_op,
    output logic [31:0] d_rdata_op,
    output logic        mem_req_op,
    output logic        mem_we_op,
    output logic [3:0]  mem_be_op,
    output logic [31:0] mem_addr_op,
    output logic [31:0] mem_wdata_op,
    input  logic        mem_gnt_ip,
    input  logic        mem_rvalid_ip,
    input  logic [31:0] mem_rdata_ip,
    output logic        busy_op,
    output logic        err_op
);

    localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;
    logic [15:0] tmo_q, tmo_d;
    logic        kill_q, kill_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        arb_any;
    logic        if_win;
    logic        resp;
    logic        tmo_hit;
    logic        done;
    logic [31:0] rsp_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        kill_d       = kill_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_gnt_op    = 1'b0;
        d_gnt_op     = 1'b0;
        if_rvalid_op = 1'b0;
        if_rdata_op  = 32'd0;
        d_rvalid_op  = 1'b0;
        d_rdata_op   = 32'd0;

        arb_any  = mem_en && (if_req_ip || d_req_ip);
        if_win   = if_req_ip && (!d_req_ip || streak_q == STARVE_L);
        resp     = (state_q == ARB_WAIT) && mem_rvalid_ip;
        // A real response in the same cycle beats the timeout
        tmo_hit  = (TIMEOUT_CYCLES != 0) && (state_q != ARB_IDLE)
                   && !resp && (32'(tmo_q) == TIMEOUT_CYCLES);
        done     = resp || tmo_hit;
        rsp_data = resp ? mem_rdata_ip : ERR_DATA;
        err_d    = err_q | tmo_hit;

        unique case (state_q)
            ARB_IDLE: begin
                tmo_d = 16'd0;
                if (!if_req_ip) streak_d = 4'd0;
                if (arb_any) begin
                    state_d = ARB_ISSUE;
                    if (if_win) begin
                        if_gnt_op = 1'b1;
                        owner_d   = OWN_IF;
                        streak_d  = 4'd0;
                        we_d      = 1'b0;
                        be_d      = 4'hF;
                        addr_d    = if_addr_ip;
                        wdata_d   = 32'd0;
                        kill_d    = if_kill_ip;
                    end else begin
                        d_gnt_op = 1'b1;
                        owner_d  = OWN_DATA;
                        if (if_req_ip && streak_q != 4'hF)
                            streak_d = streak_q + 4'd1;
                        we_d     = d_we_ip;
                        be_d     = d_be_ip;
                        addr_d   = d_addr_ip;
                        wdata_d  = d_wdata_ip;
                        kill_d   = 1'b0;
                    end
                end
            end
            ARB_ISSUE, ARB_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                if (owner_q == OWN_IF && if_kill_ip) kill_d = 1'b1;
                if (done) begin
                    state_d = ARB_IDLE;
                    owner_d = OWN_NONE;
                    kill_d  = 1'b0;
                    tmo_d   = 16'd0;
                    if (owner_q == OWN_IF && !kill_q && !if_kill_ip) begin
                        if_rvalid_op = 1'b1;
                        if_rdata_op  = rsp_data;
                    end
                    if (owner_q == OWN_DATA) begin
                        d_rvalid_op = 1'b1;
                        d_rdata_op  = rsp_data;
                    end
                end else if (state_q == ARB_ISSUE && mem_gnt_ip) begin
                    state_d = ARB_WAIT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_NONE;
            streak_q <= 4'd0;
            tmo_q    <= 16'd0;
            kill_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            kill_q   <= kill_d;
            err_q    <= err_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_req_op   = (state_q == ARB_ISSUE);
    assign mem_we_op    = we_q;
    assign mem_be_op    = be_q;
    assign mem_addr_op  = addr_q;
    assign mem_wdata_op = wdata_q;
    assign busy_op      = (state_q != ARB_IDLE);
    assign err_op       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter against a
// transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int          SL   = 4;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_en = 1'b0;
    logic        if_req_ip = 1'b0;
    logic [31:0] if_addr_ip = '0;
    logic        if_kill_ip = 1'b0;
    logic        if_gnt_op, if_rvalid_op;
    logic [31:0] if_rdata_op;
    logic        d_req_ip = 1'b0;
    logic        d_we_ip = 1'b0;
    logic [3:0]  d_be_ip = '0;
    logic [31:0] d_addr_ip = '0;
    logic [31:0] d_wdata_ip = '0;
    logic        d_gnt_op, d_rvalid_op;
    logic [31:0] d_rdata_op;
    logic        mem_req_op, mem_we_op;
    logic [3:0]  mem_be_op;
    logic [31:0] mem_addr_op, mem_wdata_op;
    logic        mem_gnt_ip = 1'b0;
    logic        mem_rvalid_ip = 1'b0;
    logic [31:0] mem_rdata_ip = '0;
    logic        busy_op, err_op;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: one outstanding transaction record
    bit          m_busy, m_acc, m_kill, m_err;
    int          m_owner, m_age, m_streak;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    bit          e_ifg, e_dg, e_done, e_tmo;

    mem_port_arbiter #(
        .STARVE_LIMIT  (SL),
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (ERRD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_en       (mem_en),
        .if_req_ip    (if_req_ip),
        .if_addr_ip   (if_addr_ip),
        .if_kill_ip   (if_kill_ip),
        .if_gnt_op    (if_gnt_op),
        .if_rvalid_op (if_rvalid_op),
        .if_rdata_op  (if_rdata_op),
        .d_req_ip     (d_req_ip),
        .d_we_ip      (d_we_ip),
        .d_be_ip      (d_be_ip),
        .d_addr_ip    (d_addr_ip),
        .d_wdata_ip   (d_wdata_ip),
        .d_gnt_op     (d_gnt_op),
        .d_rvalid_op  (d_rvalid_op),
        .d_rdata_op   (d_rdata_op),
        .mem_req_op   (mem_req_op),
        .mem_we_op    (mem_we_op),
        .mem_be_op    (mem_be_op),
        .mem_addr_op  (mem_addr_op),
        .mem_wdata_op (mem_wdata_op),
        .mem_gnt_ip   (mem_gnt_ip),
        .mem_rvalid_ip(mem_rvalid_ip),
        .mem_rdata_ip (mem_rdata_ip),
        .busy_op      (busy_op),
        .err_op       (err_op)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_kill = 0; m_err = 0;
        m_owner = 0; m_age = 0; m_streak = 0;
        m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        e_ifg = 0; e_dg = 0; e_done = 0; e_tmo = 0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ifg"}, if_gnt_op, 0);
        chk({tag, "_dg"}, d_gnt_op, 0);
        chk({tag, "_ifv"}, if_rvalid_op, 0);
        chk({tag, "_ifd"}, if_rdata_op, 0);
        chk({tag, "_dv"}, d_rvalid_op, 0);
        chk({tag, "_dd"}, d_rdata_op, 0);
        chk({tag, "_req"}, mem_req_op, 0);
        chk({tag, "_we"}, mem_we_op, 0);
        chk({tag, "_be"}, mem_be_op, 0);
        chk({tag, "_addr"}, mem_addr_op, 0);
        chk({tag, "_wd"}, mem_wdata_op, 0);
        chk({tag, "_busy"}, busy_op, 0);
        chk({tag, "_err"}, err_op, 0);
    endtask

    task automatic sample();
        bit          any, ifw, resp;
        bit          x_ifv, x_dv;
        logic [31:0] x_ifd, x_dd, rd;
        @(negedge clock);
        e_ifg = 0; e_dg = 0; e_done = 0; e_tmo = 0;
        x_ifv = 0; x_dv = 0; x_ifd = 0; x_dd = 0;
        if (!m_busy) begin
            any = mem_en && (if_req_ip || d_req_ip);
            ifw = if_req_ip && (!d_req_ip || m_streak == SL);
            e_ifg = any && ifw;
            e_dg  = any && !ifw;
        end else begin
            resp   = m_acc && mem_rvalid_ip;
            e_tmo  = !resp && (TO != 0) && (m_age == TO);
            e_done = resp || e_tmo;
            rd     = resp ? mem_rdata_ip : ERRD;
            if (e_done && m_owner == 1 && !m_kill && !if_kill_ip) begin
                x_ifv = 1; x_ifd = rd;
            end
            if (e_done && m_owner == 2) begin
                x_dv = 1; x_dd = rd;
            end
        end
        chk("m_ifgnt", if_gnt_op, e_ifg);
        chk("m_dgnt", d_gnt_op, e_dg);
        chk("m_ifrv", if_rvalid_op, x_ifv);
        chk("m_ifrd", if_rdata_op, x_ifd);
        chk("m_drv", d_rvalid_op, x_dv);
        chk("m_drd", d_rdata_op, x_dd);
        chk("m_req", mem_req_op, m_busy && !m_acc);
        chk("m_busy", busy_op, m_busy);
        chk("m_err", err_op, m_err);
        chk("m_we", mem_we_op, m_we);
        chk("m_be", mem_be_op, m_be);
        chk("m_addr", mem_addr_op, m_addr);
        chk("m_wdata", mem_wdata_op, m_wdata);
    endtask

    task automatic advance();
        if (!m_busy) begin
            if (!if_req_ip) m_streak = 0;
            if (e_ifg) begin
                m_busy = 1; m_acc = 0; m_age = 0; m_owner = 1;
                m_streak = 0; m_we = 0; m_be = 4'hF;
                m_addr = if_addr_ip; m_wdata = 0; m_kill = if_kill_ip;
            end else if (e_dg) begin
                m_busy = 1; m_acc = 0; m_age = 0; m_owner = 2;
                if (if_req_ip && m_streak < 15) m_streak++;
                m_we = d_we_ip; m_be = d_be_ip;
                m_addr = d_addr_ip; m_wdata = d_wdata_ip; m_kill = 0;
            end
        end else begin
            if (m_owner == 1 && if_kill_ip) m_kill = 1;
            if (e_done) begin
                m_busy = 0; m_owner = 0; m_kill = 0;
                if (e_tmo) m_err = 1;
            end else begin
                if (mem_gnt_ip) m_acc = 1;
                m_age++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_zero("rst0");
        @(posedge clock);
        #1;
        reset = 1'b1;
        mem_en = 1'b1;

        // single fetch, minimum latency
        if_req_ip = 1; if_addr_ip = 32'h10; mem_gnt_ip = 1;
        sample(); chk("f_gnt", if_gnt_op, 1); advance();
        if_req_ip = 0;
        sample(); chk("f_req", mem_req_op, 1);
        chk("f_addr", mem_addr_op, 32'h10); advance();
        mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h0050_0093;
        sample(); chk("f_rv", if_rvalid_op, 1);
        chk("f_rd", if_rdata_op, 32'h0050_0093); advance();
        mem_rvalid_ip = 0; mem_rdata_ip = 0;
        sample(); chk("f_idle", busy_op, 0); advance();

        // simultaneous: data first, then fetch
        if_req_ip = 1; if_addr_ip = 32'h20;
        d_req_ip = 1; d_we_ip = 0; d_be_ip = 4'hF; d_addr_ip = 32'h200;
        mem_gnt_ip = 1;
        sample(); chk("s_dgnt", d_gnt_op, 1);
        chk("s_ifgnt0", if_gnt_op, 0); advance();
        d_req_ip = 0;
        sample(); chk("s_addr", mem_addr_op, 32'h200); advance();
        mem_rvalid_ip = 1; mem_rdata_ip = 32'h1234;
        sample(); chk("s_drv", d_rvalid_op, 1);
        chk("s_drd", d_rdata_op, 32'h1234); advance();
        mem_rvalid_ip = 0;
        sample(); chk("s_ifgnt", if_gnt_op, 1); advance();
        if_req_ip = 0;
        tick();
        mem_rvalid_ip = 1; tick(); mem_rvalid_ip = 0;

        // starvation guard: D x4 then IF, repeating
        if_req_ip = 1; if_addr_ip = 32'h30;
        d_req_ip = 1; d_addr_ip = 32'h240;
        mem_gnt_ip = 1; mem_rvalid_ip = 1; mem_rdata_ip = 32'h77;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk($sformatf("st_d%0d", k), d_gnt_op, (k % 5 != 4));
            chk($sformatf("st_i%0d", k), if_gnt_op, (k % 5 == 4));
            advance();
            tick();
            tick();
        end
        if_req_ip = 0; d_req_ip = 0;
        mem_gnt_ip = 0; mem_rvalid_ip = 0;
        tick();

        // kill in WAIT, response two cycles later
        if_req_ip = 1; if_addr_ip = 32'h40; mem_gnt_ip = 1;
        sample(); chk("k_gnt", if_gnt_op, 1); advance();
        if_req_ip = 0;
        tick();
        mem_gnt_ip = 0; if_kill_ip = 1; tick(); if_kill_ip = 0;
        tick();
        mem_rvalid_ip = 1; mem_rdata_ip = 32'hABCD;
        sample(); chk("k_norv", if_rvalid_op, 0);
        chk("k_rd0", if_rdata_op, 0); advance();
        mem_rvalid_ip = 0;
        d_req_ip = 1; d_we_ip = 1; d_be_ip = 4'h3;
        d_addr_ip = 32'h300; d_wdata_ip = 32'h55AA;
        sample(); chk("k_busy0", busy_op, 0);
        chk("k_dgnt", d_gnt_op, 1); advance();
        d_req_ip = 0; mem_gnt_ip = 1;
        sample(); chk("k_we", mem_we_op, 1);
        chk("k_wd", mem_wdata_op, 32'h55AA); advance();
        mem_gnt_ip = 0; mem_rvalid_ip = 1;
        sample(); chk("k_ack", d_rvalid_op, 1); advance();
        mem_rvalid_ip = 0;

        // timeout on a load that never answers
        d_req_ip = 1; d_we_ip = 0; d_addr_ip = 32'h400; mem_gnt_ip = 1;
        sample(); chk("t_gnt", d_gnt_op, 1); advance();
        d_req_ip = 0;
        for (int i = 0; i < TO; i++) begin
            sample(); chk($sformatf("t_wait%0d", i), d_rvalid_op, 0);
            advance();
            mem_gnt_ip = 0;
        end
        sample(); chk("t_rv", d_rvalid_op, 1);
        chk("t_rd", d_rdata_op, ERRD);
        chk("t_err0", err_op, 0); advance();
        repeat (3) begin
            sample(); chk("t_err", err_op, 1);
            chk("t_idle", busy_op, 0); advance();
        end

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            if (if_req_ip && e_ifg) if_req_ip = 0;
            if (d_req_ip && e_dg) d_req_ip = 0;
            if (!if_req_ip && $urandom_range(0, 99) < 40) begin
                if_req_ip = 1;
                if_addr_ip = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req_ip && $urandom_range(0, 99) < 40) begin
                d_req_ip = 1;
                d_we_ip = 1'($urandom_range(0, 1));
                d_be_ip = 4'($urandom_range(1, 15));
                d_addr_ip = $urandom;
                d_wdata_ip = $urandom;
            end
            mem_en = ($urandom_range(0, 99) < 90);
            if_kill_ip = ($urandom_range(0, 99) < 8);
            mem_gnt_ip = ($urandom_range(0, 99) < 60);
            mem_rvalid_ip = ($urandom_range(0, 99) < 35);
            mem_rdata_ip = $urandom;
            tick();
        end

        // drain
        if_req_ip = 0; d_req_ip = 0; if_kill_ip = 0; mem_en = 1;
        mem_gnt_ip = 1; mem_rvalid_ip = 1;
        repeat (4) tick();
        mem_gnt_ip = 0; mem_rvalid_ip = 0;

        // reset in the middle of WAIT
        if_req_ip = 1; if_addr_ip = 32'h80; mem_gnt_ip = 1;
        tick();
        if_req_ip = 0;
        tick();
        mem_gnt_ip = 0;
        sample(); chk("r_inwait", busy_op, 1); advance();
        reset = 0;
        #2;
        chk_zero("r_async");
        model_reset();
        @(posedge clock);
        #1;
        reset = 1;
        mem_rvalid_ip = 1; mem_rdata_ip = 32'h777;
        sample(); chk("r_noifrv", if_rvalid_op, 0);
        chk("r_nodrv", d_rvalid_op, 0);
        chk("r_idle", busy_op, 0); advance();
        mem_rvalid_ip = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
